usb_fifo_responder: RTL and testbench
=====================================

# usb_fifo_responder

Synthesizable FT245-style USB FIFO device model: the chip side of the parallel FIFO interface driven by the FPGA's USB sequencer. It presents host-to-FPGA bytes on `rd_n` strobes and captures FPGA-to-host bytes on `wr_n` strobes, pacing the initiator with `rxf_n`/`txe_n`. A host-side valid/ready port fills and drains its two internal FIFOs. It sits opposite the sequencer in loopback builds and hardware-in-loop benches.

## Interface
- `DEPTH_LOG2`, 4, log2 of RX and TX FIFO depth (16 entries each)
- `clk  in  1` – system clock; one clock domain, rising edge.
- `reset_n  in  1` – asynchronous, active-low reset.
- `rd_n  in  1` – read strobe from initiator, active low.
- `wr_n  in  1` – write strobe from initiator, active low.
- `data_in  in  8` – byte driven by initiator during writes.
- `data_out  out  8` – RX FIFO head byte, valid while `rd_n` low.
- `rxf_n  out  1` – low when a byte is available to read.
- `txe_n  out  1` – low when a byte can be accepted.
- `host_wr_data  in  8`, `host_wr_valid  in  1`, `host_wr_ready  out  1` – push into RX FIFO.
- `host_rd_data  out  8`, `host_rd_valid  out  1`, `host_rd_ready  in  1` – pop from TX FIFO.
- `overflow  out  1` – sticky; a write strobe arrived while the TX FIFO was full.
- `underrun  out  1` – sticky; a read strobe arrived while the RX FIFO was empty.
- `panel_word  out  16`, `panel_word_valid  out  1`, `tag_error  out  1` – panel decoder outputs (see Configuration).

## Operation
- Strobes are sampled into `rd_q`/`wr_q` each cycle.
  - Read fall: `rd_n=0 && rd_q=1`. Read rise: `rd_n=1 && rd_q=0`.
  - Write fall: `wr_n=0 && wr_q=1`.
- Read path:
  - `data_out` is driven combinationally from the RX head while `rd_n` is low, and is 8'h00 otherwise.
  - On read rise, the head is popped if the RX FIFO is non-empty.
  - A read fall with the RX FIFO empty sets `underrun`; `data_out` stays 8'h00 and nothing is popped.
- Write path:
  - On write fall, `data_in` is pushed to the TX FIFO.
  - If the TX FIFO is full, the byte is dropped and `overflow` is set.
  - Holding `wr_n` low for N cycles captures exactly one byte.
- Host side:
  - `host_wr_ready` = RX FIFO not full.
  - `host_rd_valid` = TX FIFO not empty; `host_rd_data` = TX head.
  - A transfer occurs on valid&&ready at the clock edge.
- Simultaneous push and pop on the same FIFO in one cycle are both performed; the count is unchanged.
- FIFO pointers are `DEPTH_LOG2+1` bits and wrap modulo 2^(DEPTH_LOG2+1).
  - Full: MSBs differ and the remaining bits are equal.
  - Empty: pointers equal.

## Timing
- Reset values:
  - `data_out`=0, `rxf_n`=1, `txe_n`=1.
  - `host_wr_ready`=0 during reset, 1 on the first cycle after reset.
  - `host_rd_valid`=0, `host_rd_data`=0.
  - `overflow`=0, `underrun`=0, `panel_word`=0, `panel_word_valid`=0, `tag_error`=0.
  - Both FIFOs are empty; `rd_q`=`wr_q`=1.
- `rxf_n` is registered. It is high when any of the following holds:
  - the RX FIFO is empty;
  - `rd_n` is low;
  - the cycle is a read rise;
  - the cycle is the first cycle after a read rise (one-cycle precharge).
- `txe_n` is registered. It is high when the TX FIFO is full, on a write-fall cycle, or on the following cycle.
- A byte pushed from the host produces `rxf_n` low 2 cycles later: one cycle for the FIFO write, one for the register.
- A byte captured on write fall produces `host_rd_valid` high on the next cycle.
- Reset asserted mid-strobe aborts the transfer. No pop or push completes, and the FIFOs and sticky flags clear.

## Configuration
- `USB_FIFO_RESPONDER_PANEL_DECODE_EN` defined: a decoder watches each captured TX byte, independently of TX FIFO drain.
  - Byte format is {tag[7:4], nibble[3:0]}.
  - Tags 1, 2, 3, 4 fill `panel_word` bits [3:0], [7:4], [11:8], [15:12].
  - Decoder states: IDLE, GOT1, GOT2, GOT3. Tag 1 from any state restarts at GOT1.
  - Tag 4 in GOT3 updates `panel_word` and pulses `panel_word_valid` high for 1 cycle, on the cycle after capture.
  - Any other tag/state pair pulses `tag_error` for 1 cycle and returns to IDLE.
  - Dropped (overflow) bytes are not decoded.
- Macro undefined: no decoder logic; `panel_word`, `panel_word_valid` and `tag_error` are tied to 0.

## Test plan
- Host pushes 0xA5, 0x3C; initiator does 2 reads (`rd_n` low 3 cycles each) -> `data_out` is 0xA5 then 0x3C, `rxf_n` high ≥1 cycle between reads, `rxf_n` high after the second read, `underrun`=0.
- Initiator writes 0x1A, 0x2B, 0x3C, 0x4D (`wr_n` low 2 cycles each) -> host drains 0x1A, 0x2B, 0x3C, 0x4D; with the decode macro, `panel_word`=0xDCBA and a single `panel_word_valid` pulse.
- 17 writes with `host_rd_ready`=0 (depth 16) -> `txe_n`=1 after the 16th, 17th byte dropped, `overflow`=1, drain yields bytes 1–16.
- Read strobe with the RX FIFO empty -> `data_out`=0x00, `underrun`=1, pointers unchanged.
- Host push and initiator pop on the same edge with 1 byte queued -> count stays 1, order preserved.
- Writes 0x1F, 0x3F with the decode macro -> `tag_error` pulses once, `panel_word` unchanged; reset asserted mid-`rd_n` -> all outputs at reset values, FIFOs empty.

Source files
------------

// File: rtl/usb_fifo_responder.sv
// usb_fifo_responder
//   FT245-style USB FIFO chip model. The initiator reads RX bytes with rd_n
//   strobes and writes TX bytes with wr_n strobes. It is paced by rxf_n/txe_n.
//   A host-side valid/ready port fills the RX FIFO and drains the TX FIFO.
//
// Ports
//   clk, reset_n                       clock, async active-low reset
//   rd_n, wr_n, data_in                initiator strobes and write byte
//   data_out, rxf_n, txe_n             RX head byte and pacing flags
//   host_wr_data/valid/ready           host push into RX FIFO
//   host_rd_data/valid/ready           host pop from TX FIFO
//   overflow, underrun                 sticky error flags
//   panel_word, panel_word_valid,
//   tag_error                          panel decoder outputs
//
// Build option
//   USB_FIFO_RESPONDER_PANEL_DECODE_EN : enables the panel-word decoder on
//   captured TX bytes. When it is undefined, the decoder outputs are tied to 0.
module usb_fifo_responder #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        rxf_n,
    output logic        txe_n,
    input  logic [7:0]  host_wr_data,
    input  logic        host_wr_valid,
    output logic        host_wr_ready,
    output logic [7:0]  host_rd_data,
    output logic        host_rd_valid,
    input  logic        host_rd_ready,
    output logic        overflow,
    output logic        underrun,
    output logic [15:0] panel_word,
    output logic        panel_word_valid,
    output logic        tag_error
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

    logic [7:0]          rx_mem [DEPTH];
    logic [7:0]          tx_mem [DEPTH];
    logic [DEPTH_LOG2:0] rx_wp, rx_rp, tx_wp, tx_rp;
    logic                rd_q, wr_q, rise_q, wr_fall_q, rdy_q;
    logic                rx_empty, rx_full, tx_empty, tx_full;
    logic                rd_fall, rd_rise, wr_fall;
    logic                rx_push, rx_pop, tx_push, tx_pop;

    assign rx_empty = (rx_wp == rx_rp);
    assign tx_empty = (tx_wp == tx_rp);
    assign rx_full  = (rx_wp[DEPTH_LOG2] != rx_rp[DEPTH_LOG2]) &&
                      (rx_wp[DEPTH_LOG2-1:0] == rx_rp[DEPTH_LOG2-1:0]);
    assign tx_full  = (tx_wp[DEPTH_LOG2] != tx_rp[DEPTH_LOG2]) &&
                      (tx_wp[DEPTH_LOG2-1:0] == tx_rp[DEPTH_LOG2-1:0]);

    assign rd_fall = !rd_n && rd_q;
    assign rd_rise = rd_n && !rd_q;
    assign wr_fall = !wr_n && wr_q;

    // rdy_q holds host_wr_ready low while reset is asserted, even though the FIFO is empty
    assign host_wr_ready = rdy_q && !rx_full;
    assign host_rd_valid = !tx_empty;
    assign host_rd_data  = tx_empty ? 8'h00 : tx_mem[tx_rp[DEPTH_LOG2-1:0]];
    assign data_out      = (!rd_n && !rx_empty) ? rx_mem[rx_rp[DEPTH_LOG2-1:0]] : 8'h00;

    assign rx_push = host_wr_valid && host_wr_ready;
    assign rx_pop  = rd_rise && !rx_empty;
    assign tx_push = wr_fall && !tx_full;
    assign tx_pop  = host_rd_valid && host_rd_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_q      <= 1'b1;
            wr_q      <= 1'b1;
            rise_q    <= 1'b0;
            wr_fall_q <= 1'b0;
            rdy_q     <= 1'b0;
            rxf_n     <= 1'b1;
            txe_n     <= 1'b1;
            rx_wp     <= '0;
            rx_rp     <= '0;
            tx_wp     <= '0;
            tx_rp     <= '0;
            overflow  <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            rd_q      <= rd_n;
            wr_q      <= wr_n;
            rise_q    <= rd_rise;
            wr_fall_q <= wr_fall;
            rdy_q     <= 1'b1;
            // one-cycle precharge after each read rise
            rxf_n     <= rx_empty || !rd_n || rd_rise || rise_q;
            txe_n     <= tx_full || wr_fall || wr_fall_q;
            if (rx_push) rx_wp <= rx_wp + PTR_ONE;
            if (rx_pop)  rx_rp <= rx_rp + PTR_ONE;
            if (tx_push) tx_wp <= tx_wp + PTR_ONE;
            if (tx_pop)  tx_rp <= tx_rp + PTR_ONE;
            if (wr_fall && tx_full)  overflow <= 1'b1;
            if (rd_fall && rx_empty) underrun <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wp[DEPTH_LOG2-1:0]] <= host_wr_data;
        if (tx_push) tx_mem[tx_wp[DEPTH_LOG2-1:0]] <= data_in;
    end

`ifdef USB_FIFO_RESPONDER_PANEL_DECODE_EN
    typedef enum logic [1:0] {DEC_IDLE, DEC_GOT1, DEC_GOT2, DEC_GOT3} dec_state_t;

    dec_state_t  dec_state, dec_next;
    logic [11:0] shadow, shadow_next;
    logic [15:0] pw_next;
    logic        pwv_next, te_next;
    logic [3:0]  tag, nib;

    assign tag = data_in[7:4];
    assign nib = data_in[3:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dec_state        <= DEC_IDLE;
            shadow           <= '0;
            panel_word       <= '0;
            panel_word_valid <= 1'b0;
            tag_error        <= 1'b0;
        end else begin
            dec_state        <= dec_next;
            shadow           <= shadow_next;
            panel_word       <= pw_next;
            panel_word_valid <= pwv_next;
            tag_error        <= te_next;
        end
    end

    // Nibbles collect in shadow; panel_word changes only on a complete 1-2-3-4 run
    always_comb begin
        dec_next    = dec_state;
        shadow_next = shadow;
        pw_next     = panel_word;
        pwv_next    = 1'b0;
        te_next     = 1'b0;
        if (tx_push) begin
            if (tag == 4'd1) begin
                dec_next          = DEC_GOT1;
                shadow_next[3:0]  = nib;
            end else if (tag == 4'd2 && dec_state == DEC_GOT1) begin
                dec_next          = DEC_GOT2;
                shadow_next[7:4]  = nib;
            end else if (tag == 4'd3 && dec_state == DEC_GOT2) begin
                dec_next          = DEC_GOT3;
                shadow_next[11:8] = nib;
            end else if (tag == 4'd4 && dec_state == DEC_GOT3) begin
                dec_next          = DEC_IDLE;
                pw_next           = {nib, shadow};
                pwv_next          = 1'b1;
            end else begin
                dec_next          = DEC_IDLE;
                te_next           = 1'b1;
            end
        end
    end
`else
    assign panel_word       = '0;
    assign panel_word_valid = 1'b0;
    assign tag_error        = 1'b0;
`endif

endmodule

// File: tb/tb_usb_fifo_responder.sv
module tb_usb_fifo_responder;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        rd_n, wr_n;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        rxf_n, txe_n;
    logic [7:0]  host_wr_data;
    logic        host_wr_valid, host_wr_ready;
    logic [7:0]  host_rd_data;
    logic        host_rd_valid, host_rd_ready;
    logic        overflow, underrun;
    logic [15:0] panel_word;
    logic        panel_word_valid, tag_error;

    int n_tests = 0;
    int n_fail  = 0;
    int pv_cnt  = 0;
    int te_cnt  = 0;
    int tx_cnt  = 0;
    logic [7:0] rx_exp[$];
    logic [7:0] tx_exp[$];

`ifdef USB_FIFO_RESPONDER_PANEL_DECODE_EN
    localparam logic [15:0] EXP_PW = 16'hDCBA;
    localparam int          EXP_PV = 1;
    localparam int          EXP_TE = 1;
`else
    localparam logic [15:0] EXP_PW = 16'h0000;
    localparam int          EXP_PV = 0;
    localparam int          EXP_TE = 0;
`endif

    usb_fifo_responder #(.DEPTH_LOG2(4)) dut (
        .clk(clk), .reset_n(reset_n), .rd_n(rd_n), .wr_n(wr_n),
        .data_in(data_in), .data_out(data_out), .rxf_n(rxf_n), .txe_n(txe_n),
        .host_wr_data(host_wr_data), .host_wr_valid(host_wr_valid),
        .host_wr_ready(host_wr_ready), .host_rd_data(host_rd_data),
        .host_rd_valid(host_rd_valid), .host_rd_ready(host_rd_ready),
        .overflow(overflow), .underrun(underrun), .panel_word(panel_word),
        .panel_word_valid(panel_word_valid), .tag_error(tag_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (panel_word_valid === 1'b1) pv_cnt++;
        if (tag_error === 1'b1) te_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic host_push(input logic [7:0] b);
        int n = 0;
        host_wr_data  = b;
        host_wr_valid = 1'b1;
        while (host_wr_ready !== 1'b1 && n < 20) begin tick(); n++; end
        check("host_wr_ready", {31'd0, host_wr_ready}, 32'd1);
        tick();
        host_wr_valid = 1'b0;
        rx_exp.push_back(b);
    endtask

    task automatic wait_rxf_low();
        int n = 0;
        while (rxf_n !== 1'b0 && n < 20) begin tick(); n++; end
        check("rxf_low", {31'd0, rxf_n}, 32'd0);
    endtask

    // read with rd_n low for `low` cycles; data_out checked against scoreboard
    task automatic init_read(input int low);
        logic [7:0] e;
        wait_rxf_low();
        rd_n = 1'b0;
        tick();
        e = (rx_exp.size() > 0) ? rx_exp.pop_front() : 8'h00;
        check("data_out", {24'd0, data_out}, {24'd0, e});
        repeat (low - 1) tick();
        rd_n = 1'b1;
        tick();
        check("rxf_gap", {31'd0, rxf_n}, 32'd1);
    endtask

    task automatic init_write(input logic [7:0] b, input int low, input bit wait_txe);
        int n = 0;
        if (wait_txe) begin
            while (txe_n !== 1'b0 && n < 20) begin tick(); n++; end
            check("txe_low", {31'd0, txe_n}, 32'd0);
        end
        data_in = b;
        wr_n    = 1'b0;
        repeat (low) tick();
        wr_n    = 1'b1;
        tick();
        if (tx_cnt < 16) begin
            tx_exp.push_back(b);
            tx_cnt++;
        end
    endtask

    task automatic host_drain();
        logic [7:0] e;
        host_rd_ready = 1'b1;
        while (tx_exp.size() > 0) begin
            e = tx_exp.pop_front();
            check("host_rd_valid", {31'd0, host_rd_valid}, 32'd1);
            check("host_rd_data", {24'd0, host_rd_data}, {24'd0, e});
            tick();
            tx_cnt--;
        end
        host_rd_ready = 1'b0;
        check("tx_empty", {31'd0, host_rd_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        reset_n = 1'b0; rd_n = 1'b1; wr_n = 1'b1; data_in = '0;
        host_wr_data = '0; host_wr_valid = 1'b0; host_rd_ready = 1'b0;
        repeat (3) tick();
        check("rst_data_out", {24'd0, data_out}, 32'd0);
        check("rst_rxf_n", {31'd0, rxf_n}, 32'd1);
        check("rst_txe_n", {31'd0, txe_n}, 32'd1);
        check("rst_wr_ready", {31'd0, host_wr_ready}, 32'd0);
        check("rst_rd_valid", {31'd0, host_rd_valid}, 32'd0);
        check("rst_rd_data", {24'd0, host_rd_data}, 32'd0);
        check("rst_flags", {30'd0, overflow, underrun}, 32'd0);
        check("rst_panel", {15'd0, panel_word_valid, panel_word}, 32'd0);
        reset_n = 1'b1;
        tick();
        check("post_rst_ready", {31'd0, host_wr_ready}, 32'd1);
        check("post_rst_txe", {31'd0, txe_n}, 32'd0);

        // basic read path
        host_push(8'hA5);
        host_push(8'h3C);
        init_read(3);
        init_read(3);
        repeat (3) tick();
        check("rxf_after_reads", {31'd0, rxf_n}, 32'd1);
        check("no_underrun", {31'd0, underrun}, 32'd0);

        // write path + decoder
        init_write(8'h1A, 2, 1);
        init_write(8'h2B, 2, 1);
        init_write(8'h3C, 2, 1);
        init_write(8'h4D, 2, 1);
        tick();
        check("panel_word", {16'd0, panel_word}, {16'd0, EXP_PW});
        check("panel_pulses", pv_cnt, EXP_PV);
        host_drain();

        // overflow: 17 writes into depth 16
        for (int i = 1; i <= 16; i++) init_write(i[7:0], 2, 1);
        repeat (2) tick();
        check("txe_full", {31'd0, txe_n}, 32'd1);
        init_write(8'd17, 2, 0);
        check("overflow", {31'd0, overflow}, 32'd1);
        host_drain();

        // underrun on empty RX
        rd_n = 1'b0;
        tick();
        check("underrun_data", {24'd0, data_out}, 32'd0);
        rd_n = 1'b1;
        tick();
        check("underrun", {31'd0, underrun}, 32'd1);
        host_push(8'h77);
        init_read(2);

        // simultaneous host push and initiator pop
        host_push(8'h11);
        wait_rxf_low();
        rd_n = 1'b0;
        tick();
        check("sim_data0", {24'd0, data_out}, {24'd0, rx_exp.pop_front()});
        tick();
        rd_n = 1'b1;
        host_wr_data  = 8'h22;
        host_wr_valid = 1'b1;
        rx_exp.push_back(8'h22);
        tick();
        host_wr_valid = 1'b0;
        init_read(2);
        repeat (4) tick();
        check("sim_empty", {31'd0, rxf_n}, 32'd1);

        // bad tag sequence
        base = te_cnt;
        init_write(8'h1F, 2, 1);
        init_write(8'h3F, 2, 1);
        tick();
        check("tag_error", te_cnt - base, EXP_TE);
        check("panel_kept", {16'd0, panel_word}, {16'd0, EXP_PW});
        host_drain();

        // reset mid-read
        init_write(8'h5A, 2, 1);
        host_push(8'h55);
        wait_rxf_low();
        rd_n = 1'b0;
        tick();
        reset_n = 1'b0;
        #1;
        check("mid_rst_data", {24'd0, data_out}, 32'd0);
        check("mid_rst_rxf", {31'd0, rxf_n}, 32'd1);
        check("mid_rst_ready", {31'd0, host_wr_ready}, 32'd0);
        check("mid_rst_rdv", {31'd0, host_rd_valid}, 32'd0);
        check("mid_rst_flags", {30'd0, overflow, underrun}, 32'd0);
        check("mid_rst_panel", {16'd0, panel_word}, 32'd0);
        tick();
        rd_n = 1'b1;
        tick();
        reset_n = 1'b1;
        rx_exp.delete();
        tx_exp.delete();
        tx_cnt = 0;
        repeat (4) tick();
        check("post_rst_rxf", {31'd0, rxf_n}, 32'd1);
        check("post_rst_rdv", {31'd0, host_rd_valid}, 32'd0);
        check("post_rst_undr", {31'd0, underrun}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
